// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared definitions for the unified-memory arbiter.
//   state_t    : arbiter FSM encoding (IDLE / ACCESS)
//   GNT_*      : grant / owner codes
//   WORD_W     : data and address width
//   MEM_AW     : word-index width of the attached memory (256 words)
//   word_index : byte address -> memory word index, as the memory decodes it
package mips_mem_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    localparam int WORD_W = 32;
    localparam int MEM_AW = 8;

    function automatic logic [MEM_AW-1:0] word_index(input logic [WORD_W-1:0] byte_addr);
        return byte_addr[MEM_AW+1:2];
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the two requester ports, the memory port and the
// grant / debug observation signals of mem_arbiter.
//
// Handshake: a requester raises *_req with stable address (and, for D,
// we/wdata) and holds it until its *_ready pulses for one cycle; *_rdata is
// valid only while *_ready is high. A req still high during its own ready
// cycle is ignored, so the requester may drop req one cycle late.
//
//   slave  : the arbiter's view (requests + mem_rdata in; responses, memory
//            controls, grant and debug out)
//   master : the environment's view (the mirror image)
interface mem_arbiter_if #(
    parameter int CNT_W = 2
);
    import mips_mem_pkg::*;

    logic              i_req;
    logic [WORD_W-1:0] i_addr;
    logic [WORD_W-1:0] i_rdata;
    logic              i_ready;

    logic              d_req;
    logic              d_we;
    logic [WORD_W-1:0] d_addr;
    logic [WORD_W-1:0] d_wdata;
    logic [WORD_W-1:0] d_rdata;
    logic              d_ready;

    logic [WORD_W-1:0] mem_addr;
    logic              mem_write;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;

    logic [1:0]        grant;
    state_t            state_dbg;
    logic [CNT_W-1:0]  starve_dbg;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_rdata, i_ready, d_rdata, d_ready,
               mem_addr, mem_write, mem_wdata, grant, state_dbg, starve_dbg
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_rdata, i_ready, d_rdata, d_ready,
               mem_addr, mem_write, mem_wdata, grant, state_dbg, starve_dbg
    );

endinterface

// File: rtl/arb_prio2.sv
// arb_prio2: combinational two-way pick. D normally wins a tie; starve_hit
// hands the tie to I instead. At most one pick output is high.
//   i_elig, d_elig : port is requesting and not in its own ready cycle
//   starve_hit     : I has lost enough arbitrations to take priority
//   pick_i, pick_d : winner (both low when nothing is eligible)
module arb_prio2 (
    input  logic i_elig,
    input  logic d_elig,
    input  logic starve_hit,
    output logic pick_i,
    output logic pick_d
);

    assign pick_i = i_elig & (~d_elig | starve_hit);
    assign pick_d = d_elig & ~pick_i;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port unified word memory between the
// instruction-fetch port (I) and the load/store port (D). A request won in
// IDLE is latched, runs one ACCESS cycle against the memory, and completes
// with a one-cycle ready pulse on the owning port in the following cycle.
//   clk, reset : clock; synchronous active-high reset
//   bus        : mem_arbiter_if.slave (requests, responses, memory port,
//                grant, FSM state and starvation count for observation)
// Parameters:
//   STARVE_MAX : lost arbitrations (I pending) after which I wins a tie
//   CNT_W      : starvation counter width, 2**CNT_W > STARVE_MAX
module mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int STARVE_MAX = 3,
    parameter int CNT_W      = 2
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    state_t            state_q;
    state_t            state_d;
    logic [1:0]        grant_q;      // also serves as the latched owner
    logic [CNT_W-1:0]  starve_cnt;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic              we_q;
    logic [WORD_W-1:0] i_rdata_q;
    logic [WORD_W-1:0] d_rdata_q;
    logic              i_ready_q;
    logic              d_ready_q;

    logic i_elig;
    logic d_elig;
    logic starve_hit;
    logic pick_i;
    logic pick_d;
    logic arb_en;
    logic mem_write_c;

    // A port's own ready cycle masks its req so a late-dropping requester
    // is not served twice.
    assign i_elig     = bus.i_req & ~i_ready_q;
    assign d_elig     = bus.d_req & ~d_ready_q;
    assign starve_hit = (starve_cnt >= STARVE_LIM);

    arb_prio2 u_pick (
        .i_elig     (i_elig),
        .d_elig     (d_elig),
        .starve_hit (starve_hit),
        .pick_i     (pick_i),
        .pick_d     (pick_d)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        arb_en      = 1'b0;
        mem_write_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                arb_en = 1'b1;
                if (pick_i || pick_d) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // reset gates the strobe combinationally: the memory writes
                // on the falling edge, before the reset edge is seen.
                mem_write_c = we_q & ~reset;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q    <= GNT_NONE;
            starve_cnt <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            i_ready_q  <= 1'b0;
            d_ready_q  <= 1'b0;
        end else begin
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;

            if (arb_en && pick_i) begin
                addr_q     <= bus.i_addr;
                we_q       <= 1'b0;
                grant_q    <= GNT_I;
                starve_cnt <= '0;
            end else if (arb_en && pick_d) begin
                addr_q  <= bus.d_addr;
                we_q    <= bus.d_we;
                wdata_q <= bus.d_wdata;
                grant_q <= GNT_D;
                if (i_elig && (starve_cnt < STARVE_LIM))
                    starve_cnt <= starve_cnt + CNT_W'(1);
            end

            if (state_q == ST_ACCESS) begin
                grant_q <= GNT_NONE;
                if (grant_q == GNT_I) begin
                    i_ready_q <= 1'b1;
                    i_rdata_q <= bus.mem_rdata;
                end else if (grant_q == GNT_D) begin
                    d_ready_q <= 1'b1;
                    d_rdata_q <= we_q ? '0 : bus.mem_rdata;
                end
            end
        end
    end

    assign bus.i_rdata    = i_rdata_q;
    assign bus.i_ready    = i_ready_q;
    assign bus.d_rdata    = d_rdata_q;
    assign bus.d_ready    = d_ready_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.mem_write  = mem_write_c;
    assign bus.grant      = grant_q;
    assign bus.state_dbg  = state_q;
    assign bus.starve_dbg = starve_cnt;

endmodule
